// File: rtl/pulse_gen_pkg.sv
// Shared types and helpers for the pulse_gen periodic pulse-train transmitter.
// Config fields are held at a fixed maximum width so the struct is independent
// of the T_CNT_WIDTH / N_CNT_WIDTH overrides; the top zero-extends into it.
package pulse_gen_pkg;

  localparam int unsigned PG_T_MAX = 64;
  localparam int unsigned PG_N_MAX = 32;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] PG_LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    PG_IDLE,
    PG_DELAY,
    PG_HIGH,
    PG_LOW,
    PG_DONE
  } pulse_gen_state_t;

  typedef struct packed {
    logic [PG_T_MAX-1:0] period;
    logic [PG_T_MAX-1:0] width;
    logic [PG_T_MAX-1:0] delay;
    logic [PG_N_MAX-1:0] count;
  } pulse_gen_cfg_t;

  // A train needs at least one high and one low cycle per period.
  function automatic logic cfg_is_valid(input logic [PG_T_MAX-1:0] period,
                                        input logic [PG_T_MAX-1:0] width);
    return (period >= PG_T_MAX'(2)) && (width != '0) && (width < period);
  endfunction

endpackage

// File: rtl/pulse_gen_phase_cnt.sv
// Loadable down-counter with a zero flag; times the delay and high/low phases.
// Load has priority over counting; counting stops at zero.
module pulse_gen_phase_cnt
  import pulse_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt;

  // Reload on phase entry, otherwise count down to zero and hold
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (load_i) begin
      cnt <= load_val_i;
    end else if (en_i && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign zero_o = (cnt == '0);

endmodule

// File: rtl/pulse_gen.sv
// pulse_gen: programmable periodic pulse-train transmitter (N pulses or
// continuous) with cycle-exact period, width and start delay.
// Optional build macro PULSE_GEN_JITTER_EN: a 16-bit LFSR stretches the LOW
// phase by one cycle on roughly half the pulses.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned T_CNT_WIDTH = 32,
  parameter int unsigned N_CNT_WIDTH = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [T_CNT_WIDTH-1:0] cfg_period_i,
  input  logic [T_CNT_WIDTH-1:0] cfg_width_i,
  input  logic [T_CNT_WIDTH-1:0] cfg_delay_i,
  input  logic [N_CNT_WIDTH-1:0] cfg_count_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  output logic                   sig_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [N_CNT_WIDTH-1:0] pulse_cnt_o
);

  pulse_gen_state_t        state;
  pulse_gen_cfg_t          cfg_q;
  pulse_gen_cfg_t          cfg_in;
  logic                    cfg_loaded;
  logic [N_CNT_WIDTH-1:0]  pulses_left;

  logic                    cfg_acc;
  logic                    launch;
  logic                    rise;
  logic                    last_pulse;

  logic                    dly_load;
  logic                    dly_zero;
  logic                    ph_load;
  logic                    ph_zero;
  logic [T_CNT_WIDTH-1:0]  ph_load_val;
  logic [T_CNT_WIDTH-1:0]  width_m1;
  logic [T_CNT_WIDTH-1:0]  delay_m1;
  logic [T_CNT_WIDTH-1:0]  low_len_m1;

  assign cfg_in = '{period: PG_T_MAX'(cfg_period_i),
                    width:  PG_T_MAX'(cfg_width_i),
                    delay:  PG_T_MAX'(cfg_delay_i),
                    count:  PG_N_MAX'(cfg_count_i)};

  // cfg_ready_o is only ever high while state is IDLE, so acceptance implies IDLE.
  // A config accepted in the same cycle as start_i takes precedence over the launch.
  assign cfg_acc    = cfg_valid_i && cfg_ready_o;
  assign launch     = (state == PG_IDLE) && start_i && !stop_i && !cfg_acc &&
                      cfg_loaded && !err_o;
  assign rise       = (state == PG_HIGH) && !sig_o && !stop_i;
  assign last_pulse = (cfg_q.count != '0) && (pulses_left == N_CNT_WIDTH'(1));

  // Differences are formed at full config width, then narrowed; no wrap at max period.
  assign width_m1 = T_CNT_WIDTH'(cfg_q.width - PG_T_MAX'(1));
  assign delay_m1 = T_CNT_WIDTH'(cfg_q.delay - PG_T_MAX'(1));

`ifdef PULSE_GEN_JITTER_EN
  logic [15:0] lfsr;
  logic        low_stretch;

  // Stretch only when period-width+1 still fits the counter width.
  assign low_stretch = lfsr[0] && (T_CNT_WIDTH'(cfg_q.period - cfg_q.width) != '1);
  assign low_len_m1  = T_CNT_WIDTH'(cfg_q.period - cfg_q.width - PG_T_MAX'(1)) +
                       T_CNT_WIDTH'(low_stretch);

  // Advance the jitter LFSR once per pulse, at the HIGH-to-LOW transition
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr <= LFSR_SEED;
    end else if ((state == PG_HIGH) && ph_zero && !stop_i) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? PG_LFSR_TAPS : 16'h0000);
    end
  end
`else
  assign low_len_m1 = T_CNT_WIDTH'(cfg_q.period - cfg_q.width - PG_T_MAX'(1));
`endif

  // Phase counter reloads: each phase is loaded with its length minus one on entry
  always_comb begin
    dly_load    = 1'b0;
    ph_load     = 1'b0;
    ph_load_val = width_m1;
    if (!stop_i) begin
      unique case (state)
        PG_IDLE: begin
          if (launch) begin
            if (cfg_q.delay != '0) dly_load = 1'b1;
            else                   ph_load  = 1'b1;
          end
        end
        PG_DELAY: ph_load = dly_zero;
        PG_HIGH: begin
          ph_load     = ph_zero;
          ph_load_val = low_len_m1;
        end
        PG_LOW:  ph_load = ph_zero && !last_pulse;
        default: ;
      endcase
    end
  end

  pulse_gen_phase_cnt #(.WIDTH(T_CNT_WIDTH)) u_dly_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (dly_load),
    .load_val_i (delay_m1),
    .en_i       (state == PG_DELAY),
    .zero_o     (dly_zero)
  );

  pulse_gen_phase_cnt #(.WIDTH(T_CNT_WIDTH)) u_ph_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (ph_load),
    .load_val_i (ph_load_val),
    .en_i       ((state == PG_HIGH) || (state == PG_LOW)),
    .zero_o     (ph_zero)
  );

  // Main FSM plus config latch and registered outputs.
  // sig_o/busy_o/done_o are registered decodes of the state, so they trail it
  // by one cycle; this is what places the first rise at start edge + 1 + delay.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= PG_IDLE;
      cfg_q       <= '0;
      cfg_loaded  <= 1'b0;
      pulses_left <= '0;
      cfg_ready_o <= 1'b1;
      sig_o       <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      pulse_cnt_o <= '0;
    end else begin
      sig_o  <= (state == PG_HIGH) && !stop_i;
      busy_o <= (state inside {PG_DELAY, PG_HIGH, PG_LOW}) && !stop_i;
      done_o <= (state == PG_DONE) && !stop_i;

      if (rise && (pulse_cnt_o != '1)) begin
        pulse_cnt_o <= pulse_cnt_o + N_CNT_WIDTH'(1);
      end

      if (stop_i && (state != PG_IDLE)) begin
        state       <= PG_IDLE;
        cfg_ready_o <= 1'b1;
      end else begin
        unique case (state)
          PG_IDLE: begin
            if (cfg_acc) begin
              cfg_q      <= cfg_in;
              cfg_loaded <= 1'b1;
              err_o      <= !cfg_is_valid(cfg_in.period, cfg_in.width);
            end else if (launch) begin
              pulse_cnt_o <= '0;
              pulses_left <= N_CNT_WIDTH'(cfg_q.count);
              cfg_ready_o <= 1'b0;
              state       <= (cfg_q.delay != '0) ? PG_DELAY : PG_HIGH;
            end
          end
          PG_DELAY: begin
            if (dly_zero) state <= PG_HIGH;
          end
          PG_HIGH: begin
            if (ph_zero) state <= PG_LOW;
          end
          PG_LOW: begin
            if (ph_zero) begin
              if (last_pulse) begin
                state <= PG_DONE;
              end else begin
                state <= PG_HIGH;
                if (cfg_q.count != '0) pulses_left <= pulses_left - N_CNT_WIDTH'(1);
              end
            end
          end
          PG_DONE: begin
            state       <= PG_IDLE;
            cfg_ready_o <= 1'b1;
          end
          default: begin
            state       <= PG_IDLE;
            cfg_ready_o <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
